// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and HI/LO occupancy
// stalls, jump squash, interrupt entry and eret return with a one-level mask.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic       load_E,
  input  logic [4:0] wa_E,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic       md_use_D,
  input  logic       jump_D,
  input  logic       int_req,
  input  logic       eret_M,
  output logic       pc_en,
  output logic       dreg_en,
  output logic       dreg_flush,
  output logic       exc_flush,
  output logic       ereg_flush,
  output logic [1:0] pc_sel,
  output logic       epc_we,
  output logic       md_busy,
  output logic       int_mask
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] r_md_cnt;
  logic             r_md_busy;
  logic             r_int_mask;

  logic w_eret_acc;
  logic w_int_acc;
  logic w_exc;
  logic w_lu_stall;
  logic w_md_stall;
  logic w_stall;
  logic w_md_go;

  // eret wins over a pending interrupt; the masked request stays pending.
  assign w_eret_acc = eret_M;
  assign w_int_acc  = int_req & ~r_int_mask & ~eret_M;
  assign w_exc      = w_eret_acc | w_int_acc;

  assign w_lu_stall = load_E & (wa_E != 5'd0) &
                      ((use_rs_D & (rs_D == wa_E)) | (use_rt_D & (rt_D == wa_E)));
  assign w_md_stall = md_use_D & (r_md_busy | md_start_E);
  assign w_stall    = ~w_exc & (w_lu_stall | w_md_stall);
  assign w_md_go    = md_start_E & ~w_exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt   <= '0;
      r_md_busy  <= 1'b0;
      r_int_mask <= 1'b0;
    end else begin
      if (w_int_acc) begin
        r_int_mask <= 1'b1;
      end else if (w_eret_acc) begin
        r_int_mask <= 1'b0;
      end

      // An exception while busy keeps counting: the mult/div already issued.
      if (w_md_go) begin
        r_md_cnt  <= md_div_E ? DIV_LOAD : MULT_LOAD;
        r_md_busy <= 1'b1;
      end else if (r_md_busy) begin
        r_md_cnt <= r_md_cnt - CNT_W'(1);
        if (r_md_cnt == CNT_W'(1)) begin
          r_md_busy <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    dreg_en    = 1'b1;
    dreg_flush = 1'b0;
    exc_flush  = 1'b0;
    ereg_flush = 1'b0;
    pc_sel     = 2'b00;
    epc_we     = 1'b0;
    md_busy    = r_md_busy | w_md_go;
    int_mask   = r_int_mask;
    if (reset) begin
      pc_en    = 1'b0;
      dreg_en  = 1'b0;
      md_busy  = 1'b0;
      int_mask = 1'b0;
    end else if (w_exc) begin
      exc_flush  = 1'b1;
      ereg_flush = 1'b1;
      dreg_flush = 1'b1;
      dreg_en    = 1'b0;
      pc_sel     = w_eret_acc ? 2'b10 : 2'b01;
      epc_we     = w_int_acc;
    end else if (w_stall) begin
      pc_en      = 1'b0;
      dreg_en    = 1'b0;
      ereg_flush = 1'b1;
    end else if (jump_D) begin
      dreg_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected output vectors.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, wa_E;
  logic       use_rs_D, use_rt_D, load_E;
  logic       md_start_E, md_div_E, md_use_D;
  logic       jump_D, int_req, eret_M;
  logic       pc_en, dreg_en, dreg_flush, exc_flush, ereg_flush;
  logic [1:0] pc_sel;
  logic       epc_we, md_busy, int_mask;

  int checkCount = 0;
  int passCount  = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .load_E(load_E), .wa_E(wa_E),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
    .jump_D(jump_D), .int_req(int_req), .eret_M(eret_M),
    .pc_en(pc_en), .dreg_en(dreg_en), .dreg_flush(dreg_flush),
    .exc_flush(exc_flush), .ereg_flush(ereg_flush), .pc_sel(pc_sel),
    .epc_we(epc_we), .md_busy(md_busy), .int_mask(int_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: pc_en dreg_en dreg_flush exc_flush ereg_flush pc_sel[1:0] epc_we md_busy int_mask
  logic [9:0] obs;
  assign obs = {pc_en, dreg_en, dreg_flush, exc_flush, ereg_flush, pc_sel, epc_we, md_busy, int_mask};

  localparam logic [9:0] RESET_V   = 10'b0_0_0_0_0_00_0_0_0;
  localparam logic [9:0] RUN       = 10'b1_1_0_0_0_00_0_0_0;
  localparam logic [9:0] RUN_MASK  = 10'b1_1_0_0_0_00_0_0_1;
  localparam logic [9:0] STALL     = 10'b0_0_0_0_1_00_0_0_0;
  localparam logic [9:0] STALL_MD  = 10'b0_0_0_0_1_00_0_1_0;
  localparam logic [9:0] STALL_MDM = 10'b0_0_0_0_1_00_0_1_1;
  localparam logic [9:0] JUMP      = 10'b1_1_1_0_0_00_0_0_0;
  localparam logic [9:0] INT_ENTRY = 10'b1_0_1_1_1_01_1_0_0;
  localparam logic [9:0] INT_MD    = 10'b1_0_1_1_1_01_1_1_0;
  localparam logic [9:0] ERET_M1   = 10'b1_0_1_1_1_10_0_0_1;
  localparam logic [9:0] ERET_M0   = 10'b1_0_1_1_1_10_0_0_0;

  // Advance to just after the rising edge and return every input to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    reset = 1'b0; rs_D = 5'd0; rt_D = 5'd0; wa_E = 5'd0;
    use_rs_D = 1'b0; use_rt_D = 1'b0; load_E = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
    jump_D = 1'b0; int_req = 1'b0; eret_M = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    #3;
    checkCount++;
    assert (obs === expected) passCount++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
  endtask

  initial begin
    reset = 1'b1; rs_D = 5'd0; rt_D = 5'd0; wa_E = 5'd0;
    use_rs_D = 1'b0; use_rt_D = 1'b0; load_E = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
    jump_D = 1'b0; int_req = 1'b0; eret_M = 1'b0;

    applyStimulus(); reset = 1'b1; checkOutput("reset0", RESET_V);
    applyStimulus(); reset = 1'b1; int_req = 1'b1; jump_D = 1'b1; checkOutput("reset1", RESET_V);
    applyStimulus(); checkOutput("idle", RUN);

    applyStimulus(); load_E = 1'b1; wa_E = 5'd8; rs_D = 5'd8; use_rs_D = 1'b1;
    checkOutput("lu_rs", STALL);
    applyStimulus(); rs_D = 5'd8; use_rs_D = 1'b1; checkOutput("lu_release", RUN);
    applyStimulus(); load_E = 1'b1; wa_E = 5'd0; rs_D = 5'd0; use_rs_D = 1'b1;
    checkOutput("lu_r0", RUN);
    applyStimulus(); load_E = 1'b1; wa_E = 5'd5; rt_D = 5'd5; use_rt_D = 1'b1;
    checkOutput("lu_rt", STALL);
    applyStimulus(); load_E = 1'b1; wa_E = 5'd5; rt_D = 5'd5; use_rt_D = 1'b0;
    checkOutput("lu_rt_unused", RUN);
    applyStimulus(); load_E = 1'b1; wa_E = 5'd5; rs_D = 5'd6; use_rs_D = 1'b1;
    checkOutput("lu_nomatch", RUN);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(); md_start_E = (i == 0); md_div_E = 1'b0; md_use_D = 1'b1;
      checkOutput($sformatf("mult_stall_%0d", i), STALL_MD);
    end
    applyStimulus(); md_use_D = 1'b1; checkOutput("mult_done", RUN);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(); md_start_E = (i == 0); md_div_E = (i == 0); md_use_D = 1'b1;
      checkOutput($sformatf("div_stall_%0d", i), STALL_MD);
    end
    applyStimulus(); md_use_D = 1'b1; checkOutput("div_done", RUN);

    applyStimulus(); jump_D = 1'b1; load_E = 1'b1; wa_E = 5'd3; rs_D = 5'd3; use_rs_D = 1'b1;
    checkOutput("jump_stalled", STALL);
    applyStimulus(); jump_D = 1'b1; checkOutput("jump_taken", JUMP);

    applyStimulus(); int_req = 1'b1; checkOutput("int_entry", INT_ENTRY);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(); int_req = 1'b1;
      checkOutput($sformatf("int_masked_%0d", i), RUN_MASK);
    end
    applyStimulus(); int_req = 1'b1; eret_M = 1'b1; checkOutput("eret", ERET_M1);
    applyStimulus(); int_req = 1'b1; checkOutput("int_reentry", INT_ENTRY);
    applyStimulus(); eret_M = 1'b1; checkOutput("eret2", ERET_M1);
    applyStimulus(); checkOutput("unmasked_idle", RUN);

    applyStimulus(); eret_M = 1'b1; int_req = 1'b1; jump_D = 1'b1;
    load_E = 1'b1; wa_E = 5'd9; rt_D = 5'd9; use_rt_D = 1'b1;
    checkOutput("simultaneous", ERET_M0);
    applyStimulus(); checkOutput("after_simul", RUN);

    applyStimulus(); md_start_E = 1'b1; md_div_E = 1'b1; int_req = 1'b1;
    checkOutput("md_squashed", INT_ENTRY);
    applyStimulus(); md_use_D = 1'b1; checkOutput("md_discarded", RUN_MASK);
    applyStimulus(); eret_M = 1'b1; checkOutput("eret3", ERET_M1);
    applyStimulus(); checkOutput("idle2", RUN);

    applyStimulus(); md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
    checkOutput("div2_c0", STALL_MD);
    applyStimulus(); md_use_D = 1'b1; int_req = 1'b1; checkOutput("div2_int", INT_MD);
    applyStimulus(); md_use_D = 1'b1; checkOutput("div2_c2", STALL_MDM);
    applyStimulus(); reset = 1'b1; md_use_D = 1'b1; checkOutput("div2_reset", RESET_V);
    applyStimulus(); md_use_D = 1'b1; checkOutput("post_reset", RUN);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the PC enable and the enable/flush inputs of the F/D, D/E and E/M pipeline registers, including the Iferet_M/jump_flush squash inputs of the decode register.
- Resolves load-use hazards, tracks multi-cycle mult/div occupancy of HI/LO, and sequences interrupt entry and eret return with a one-level interrupt mask.

Parameters:
- MULT_CYCLES, 5, total cycles a mult/multu occupies HI/LO (≥2).
- DIV_CYCLES, 10, total cycles a div/divu occupies HI/LO (≥2).
- CNT_W, 4, width of the mult/div down-counter (must hold DIV_CYCLES-1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- rs_D  in  5  rs field of instruction in D.
- rt_D  in  5  rt field of instruction in D.
- use_rs_D  in  1  D instruction reads rs.
- use_rt_D  in  1  D instruction reads rt.
- load_E  in  1  E instruction is a load.
- wa_E  in  5  destination register of E instruction.
- md_start_E  in  1  mult/div instruction is in E this cycle.
- md_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult.
- md_use_D  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- jump_D  in  1  taken branch/jump resolved in D.
- int_req  in  1  external interrupt request (level).
- eret_M  in  1  eret in M.
- pc_en  out  1  PC register enable.
- dreg_en  out  1  D register enable.
- dreg_flush  out  1  D register squash (ties to jump_flush).
- exc_flush  out  1  squash D/E/M (ties to Iferet_M and E/M flush).
- ereg_flush  out  1  insert bubble into E.
- pc_sel  out  2  00 sequential/jump, 01 interrupt vector, 10 EPC.
- epc_we  out  1  capture EPC this cycle.
- md_busy  out  1  HI/LO unit occupied.
- int_mask  out  1  interrupts blocked.

Behaviour:
- All outputs are combinational from registered state (md_cnt, md_busy_r, int_mask_r) and the current-cycle inputs. Registered state updates on posedge clk.
- Reset, in the same cycle it is sampled:
  - md_cnt=0, md_busy_r=0, int_mask_r=0.
  - While reset is high, outputs are forced to: pc_en=0, dreg_en=0, all flushes 0, pc_sel=00, epc_we=0.
  - Reset mid-mult/div cancels occupancy immediately.
- Events are evaluated in this priority order.
- eret_acc = eret_M.
- int_acc = int_req & ~int_mask_r & ~eret_M.
- exc = eret_acc | int_acc. When exc:
  - exc_flush=1, ereg_flush=1, dreg_flush=1, pc_en=1, dreg_en=0.
  - pc_sel=10 on eret, 01 on interrupt.
  - epc_we=int_acc.
  - The stall and jump rules below are ignored this cycle.
- int_mask_r: set at the edge ending an int_acc cycle; cleared at the edge ending an eret_acc cycle.
- lu_stall = load_E & (wa_E≠0) & ((use_rs_D & rs_D==wa_E) | (use_rt_D & rt_D==wa_E)).
- md_stall = md_use_D & (md_busy_r | md_start_E).
- stall = ~exc & (lu_stall | md_stall). When stall: pc_en=0, dreg_en=0, ereg_flush=1, dreg_flush=0.
- Jump: jump_D & ~exc & ~stall gives dreg_flush=1, pc_en=1, dreg_en=1. A jump under stall waits until the stall releases.
- Otherwise: pc_en=1, dreg_en=1, all flushes 0, pc_sel=00.
- Mult/div counter:
  - On md_start_E & ~exc: md_cnt loads (md_div_E ? DIV_CYCLES : MULT_CYCLES)-1 and md_busy_r goes to 1.
  - md_start_E during exc is discarded, because the E instruction is squashed.
  - While md_busy_r: md_cnt decrements each cycle. When md_cnt==1 and it decrements to 0, md_busy_r clears at the same edge.
  - An exception during busy does NOT cancel the count.
  - md_busy = md_busy_r | (md_start_E & ~exc).
- A stalled md_start_E cannot recur, because md_start_E is only asserted by an instruction in E and bubbles follow it.

Test Plan:
- Load-use: load_E=1, wa_E=8, rs_D=8, use_rs_D=1 for 1 cycle → pc_en=0, dreg_en=0, ereg_flush=1 that cycle; next cycle, with load_E=0, all enables return to 1. Same stimulus with wa_E=0 → no stall.
- Mult: md_start_E, md_div_E=0 at T, then md_use_D=1 held → md_busy high T..T+4 and stall T..T+4; pc_en=1 at T+5. Repeat with div → stall through T+9.
- Jump vs stall: jump_D=1 with lu_stall at T → dreg_flush=0 at T; at T+1 jump_D=1 with no stall → dreg_flush=1, pc_en=1.
- Interrupt: int_req=1 at T → exc_flush=1, pc_sel=01, epc_we=1 at T; int_mask=1 from T+1; int_req held → no second acceptance. eret_M at T+6 → pc_sel=10, epc_we=0; int_mask=0 at T+7, and a held int_req is accepted at T+7.
- Simultaneous: eret_M=1, int_req=1, lu_stall=1 and jump_D=1 in one cycle → pc_sel=10, epc_we=0, pc_en=1, ereg_flush=1, dreg_flush=1.
- Reset mid-div: reset at cycle 3 of a div → md_busy=0 the cycle after reset deasserts, int_mask=0, and md_use_D no longer stalls.
